// File: rtl/task_ingress_arbiter_pkg.sv
// rtl/task_ingress_arbiter_pkg.sv - shared FSM encoding and width helper for the ingress arbiter
package task_ingress_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HOLD   = 2'd1,
    ST_RESUME = 2'd2
  } state_t;

  // Bits needed to index `value` distinct items (value >= 2).
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/task_ingress_arbiter_rr_arbiter.sv
// rtl/task_ingress_arbiter_rr_arbiter.sv - combinational round-robin picker (rotate, priority-encode, un-rotate)
module rr_arbiter
  import task_ingress_arbiter_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] a, input int b);
    int s;
    s = int'(a) + b;
    if (s >= N) s = s - N;
    return IW'(s);
  endfunction

  logic [N-1:0]  rot;
  logic [IW-1:0] pe;
  logic          hit;

  always_comb begin
    rot     = '0;
    pe      = '0;
    hit     = 1'b0;
    gnt     = '0;
    gnt_idx = '0;
    for (int k = 0; k < N; k++) begin
      rot[k] = req[wrap_add(ptr, k)];
    end
    // Descending scan so the lowest rotated position (closest to ptr) wins.
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) begin
        pe  = IW'(k);
        hit = 1'b1;
      end
    end
    gnt_idx = wrap_add(ptr, int'(pe));
    if (en && hit) gnt[gnt_idx] = 1'b1;
  end

endmodule

// File: rtl/task_ingress_arbiter.sv
// rtl/task_ingress_arbiter.sv - credit-gated round-robin sharing of the scheduler task-insertion port
module task_ingress_arbiter
  import task_ingress_arbiter_pkg::*;
#(
  parameter int W    = 42,
  parameter int R_Q  = 64,
  parameter int NREQ = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NREQ-1:0]               req_valid,
  input  logic [(W-1)*NREQ-1:0]         req_task,
  output logic [NREQ-1:0]               req_ready,
  input  logic                          repair_period,
  input  logic                          credit_ret,
  output logic                          wr,
  output logic [W-2:0]                  task_out,
  output logic [clog2(NREQ)-1:0]        grant_id,
  output logic [clog2(R_Q+1)-1:0]       credits,
  output logic [1:0]                    state_o,
  output logic                          ovf_err
);

  localparam int TW = W - 1;
  localparam int IW = clog2(NREQ);
  localparam int CW = clog2(R_Q + 1);

  state_t          state;
  state_t          state_nxt;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   win_idx;
  logic [NREQ-1:0] gnt;
  logic            grant_en;
  logic            granted;
  logic [TW-1:0]   win_task;

  // A credit returned this cycle is not spendable until the next one.
  assign grant_en = !rst && (state == ST_RUN) && !repair_period && (credits != '0);

  rr_arbiter #(.N(NREQ), .IW(IW)) u_rr (
    .req     (req_valid),
    .ptr     (ptr),
    .en      (grant_en),
    .gnt     (gnt),
    .gnt_idx (win_idx)
  );

  assign req_ready = gnt;
  assign granted   = |gnt;
  assign state_o   = state;

  always_comb begin
    win_task = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) win_task = req_task[i*TW +: TW];
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:    if (repair_period) state_nxt = ST_HOLD;
      ST_HOLD:   if (!repair_period) state_nxt = ST_RESUME;
      ST_RESUME: state_nxt = repair_period ? ST_HOLD : ST_RUN;
      default:   state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_RUN;
      ptr      <= '0;
      wr       <= 1'b0;
      task_out <= '0;
      grant_id <= '0;
      credits  <= CW'(R_Q);
      ovf_err  <= 1'b0;
    end else begin
      state <= state_nxt;
      wr    <= granted;
      if (granted) begin
        task_out <= win_task;
        grant_id <= win_idx;
        ptr      <= (win_idx == IW'(NREQ - 1)) ? '0 : win_idx + IW'(1);
      end
      if (granted && !credit_ret) begin
        credits <= credits - CW'(1);
      end else if (!granted && credit_ret) begin
        if (credits == CW'(R_Q)) ovf_err <= 1'b1;
        else                     credits <= credits + CW'(1);
      end
    end
  end

endmodule

// File: doc/task_ingress_arbiter.md
Name: task_ingress_arbiter

Overview:
- Shares the scheduler's single task-insertion port (`wr` / `task_in`) among NREQ independent task producers, such as host interfaces and replica generators.
- Arbitration is round-robin.
- Tracks ready-queue occupancy with credits, so the scheduler never receives a task it cannot queue.
- Freezes insertion while the control unit holds the repair period. Sits directly in front of the scheduler's task input.

Parameters:
- W, 42, task word width used across the scheduler; the task payload is W-1 bits.
- R_Q, 64, ready-queue depth; this is the initial and maximum credit count.
- NREQ, 4, number of requester ports (>=2).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  NREQ  per-requester task valid
- req_task  in  (W-1)*NREQ  per-requester task; requester i occupies bits [(i+1)*(W-1)-1 : i*(W-1)]
- req_ready  out  NREQ  one-hot accept; a transfer occurs when `req_valid[i]` and `req_ready[i]` are both high
- repair_period  in  1  repair period from the control unit; blocks all grants
- credit_ret  in  1  one-cycle pulse: the scheduler removed one task from its ready queue
- wr  out  1  insertion strobe to the scheduler
- task_out  out  W-1  task presented with `wr`
- grant_id  out  clog2(NREQ)  index of the requester whose task is on `task_out`
- credits  out  clog2(R_Q+1)  current free ready-queue slots
- state_o  out  2  FSM state, for debug
- ovf_err  out  1  sticky credit-overflow flag

Behaviour:
- Reset (synchronous, rst=1 at a rising edge) sets:
  - wr=0, task_out=0, grant_id=0
  - credits=R_Q, ovf_err=0
  - RR pointer=0, state=RUN
  - `req_ready` is 0 while rst is high.
- FSM states are RUN, HOLD and RESUME.
  - RUN -> HOLD when repair_period=1.
  - HOLD -> RESUME when repair_period=0.
  - RESUME -> RUN unconditionally after 1 cycle. RESUME -> HOLD if repair_period=1 again.
  - Grants are issued only in RUN with repair_period=0. RESUME is a one-cycle guard with no grant.
- Grant (combinational in the cycle of acceptance):
  - Eligible when state=RUN, repair_period=0, credits>0 and |req_valid.
  - The winner is the first valid requester searching upward from the pointer, wrapping NREQ-1 -> 0.
  - `req_ready` is one-hot on the winner, else all-zero.
  - A non-selected requester's `req_ready` is always 0, regardless of its valid.
- Pointer: after a grant to requester i, pointer <= (i+1) mod NREQ. Without a grant the pointer holds.
- Latency and throughput:
  - A task accepted in cycle t appears at t+1 as wr=1 with task_out=that task and grant_id=i.
  - Throughput is one task per cycle. wr is 0 in any cycle following a no-grant cycle.
  - task_out holds its last value when wr=0.
- Credits:
  - A grant (not wr) consumes the credit in the acceptance cycle.
  - Grant and no credit_ret: credits-1.
  - credit_ret and no grant: credits+1.
  - Both in the same cycle: unchanged.
  - credits==0 blocks grants in that cycle. A same-cycle credit_ret does not enable a grant; it becomes usable next cycle.
  - credit_ret while credits==R_Q and no grant: credits stay R_Q and ovf_err <= 1 (sticky until reset).
- repair_period rising in the cycle after an acceptance: the registered wr still issues (the task is already committed), and no new grant is made.
- Requester protocol: a requester must hold `req_valid` and `req_task` stable until accepted. The arbiter stores nothing besides the single output register.
- Reset mid-operation: a pending registered task is dropped (wr=0 next cycle) and credits return to R_Q. Upstream producers must re-issue the task.

Decomposition:
- Shared package: FSM state encoding (RUN=0, HOLD=1, RESUME=2) and the clog2 helper for the `grant_id` and `credits` widths.
- One sub-module, rr_arbiter:
  - Parameter N; inputs req[N], ptr, en; outputs gnt one-hot and gnt_idx.
  - Purely combinational, implemented as a rotate, priority-encode and un-rotate.
- The FSM, credit counter, pointer register and output register stay in task_ingress_arbiter.

Test Plan:
1. Reset, with R_Q=4 and NREQ=4 -> wr=0, credits=4, state_o=RUN, ovf_err=0, req_ready=0 while rst=1.
2. All four requesters valid continuously, credit_ret pulsing each cycle -> grant_id sequence 0,1,2,3,0,1 on consecutive cycles and wr high every cycle after the first acceptance. With only req 1 and req 3 valid -> grant_id 1,3,1,3.
3. R_Q=4, no credit_ret, all requesters valid -> exactly 4 wr pulses, then credits=0 and req_ready=0. One credit_ret pulse -> the next cycle grants exactly one task and credits return to 0.
4. repair_period high for 5 cycles during continuous requests -> no req_ready during HOLD. The in-flight task is still written in the first HOLD cycle. After repair_period falls, one RESUME cycle with no grant, then grants resume from the saved pointer.
5. Grant and credit_ret in the same cycle at credits=2 -> credits stays 2. credit_ret at credits=4 with idle requesters -> credits=4 and ovf_err=1, which persists until rst.
6. rst asserted for one cycle right after an acceptance -> wr=0 next cycle, credits=R_Q, pointer=0.
